cam_pool2x2: RTL and testbench
==============================

CAM_POOL2X2 -- requirements
Module: cam_pool2x2

Interface
REQ-001 SHALL have parameter COLS, 64, input pixels per row (even, >=4).
REQ-002 SHALL have parameter ROWS, 64, input rows per frame (even, >=2).
REQ-003 SHALL have parameter DATA_W, 16, per-channel pixel width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port in_valid_i  input  1  input pixel valid.
REQ-007 SHALL have port in_ready_o  output  1  input pixel accepted when valid&&ready.
REQ-008 SHALL have port in_sof_i  input  1  pixel is first of frame (row 0, col 0).
REQ-009 SHALL have ports in_r_i, in_g_i, in_b_i  input  DATA_W each  pixel channels.
REQ-010 SHALL have port out_valid_o  output  1  pooled pixel valid.
REQ-011 SHALL have port out_ready_i  input  1  downstream accept.
REQ-012 SHALL have ports out_r_o, out_g_o, out_b_o  output  DATA_W each  pooled channels.
REQ-013 SHALL have port out_col_o  output  clog2(COLS/2)  pooled column index.
REQ-014 SHALL have port out_row_o  output  clog2(ROWS/2)  pooled row index.
REQ-015 SHALL have port out_eof_o  output  1  marks final pooled pixel of frame.
REQ-016 SHALL have port sof_err_o  output  1  sticky: pixel accepted outside a frame, or sof mid-frame.

Function
REQ-017 SHALL accept pixels in raster order; column counter wraps COLS-1->0 and increments row counter.
REQ-018 SHALL use states IDLE (await sof), RUN; IDLE->RUN on accepted pixel with in_sof_i=1; RUN->IDLE after accepting pixel (ROWS-1, COLS-1).
REQ-019 SHALL, in IDLE, accept and discard pixels with in_sof_i=0 and set sof_err_o.
REQ-020 SHALL, in RUN, on accepted in_sof_i=1, set sof_err_o, restart counters at (0,0), treat pixel as first of a new frame; partial pooled outputs of old frame not emitted.
REQ-021 SHALL hold even-column pixel per channel; on odd column form pair sum (DATA_W+1 bits, no overflow).
REQ-022 SHALL, on even rows, write pair sum to line buffer entry col/2 (COLS/2 entries x 3 channels x DATA_W+1).
REQ-023 SHALL, on odd rows, form pair sum + line buffer entry (DATA_W+2 bits) and output bits [DATA_W+1:2] (truncating divide by 4).
REQ-024 SHALL register outputs: out_valid_o rises cycle after the odd-row/odd-column pixel is accepted; out_col_o=col/2, out_row_o=row/2.
REQ-025 SHALL assert out_eof_o with the pooled pixel (ROWS/2-1, COLS/2-1) only.
REQ-026 SHALL hold out_* stable while out_valid_o=1 and out_ready_i=0; clear out_valid_o on handshake unless a new result loads same cycle.
REQ-027 SHALL drive in_ready_o = ~out_valid_o | out_ready_i (combinational); no pixel dropped under backpressure.
REQ-028 SHALL sustain one input pixel per cycle when out_ready_i=1.
REQ-029 SHALL clear sof_err_o only on reset.

Reset
REQ-030 SHALL, on resetn=0 at clk edge, enter IDLE, zero counters, out_valid_o=0, out_eof_o=0, out_r/g/b_o=0, out_col_o=0, out_row_o=0, sof_err_o=0; in_ready_o=1 after reset.
REQ-031 SHALL not require line buffer/pair-hold contents to be reset (overwritten before use).
REQ-032 SHALL, on reset mid-frame, abandon frame; no output until next sof frame completes a 2x2 block.

Verification
REQ-033 SHALL cover: COLS=4,ROWS=2, R pixels row0 {4,8,12,16}, row1 {4,8,12,16}, out_ready=1 -> outputs R=6 @(0,0), R=14 @(0,1) with out_eof_o=1.
REQ-034 SHALL cover: all channels 0xFFFF full frame -> every output 0xFFFF (no overflow).
REQ-035 SHALL cover: R sums 1+1+1+2=5 -> out_r_o=1 (truncation).
REQ-036 SHALL cover: out_ready_i=0 for 10 cycles with output pending -> in_ready_o=0, out_* stable, no loss; stream resumes at 1 px/cycle.
REQ-037 SHALL cover: pixels without sof in IDLE, then sof mid-frame -> sof_err_o=1 sticky, new frame output correct from (0,0).
REQ-038 SHALL cover: resetn=0 during row 1 then new frame -> all outputs zero, first output only after new frame's block (0,0).

Source files
------------

// File: rtl/cam_pool2x2.sv
// 2x2 average pooling of a raster-order RGB pixel stream.
// Each pooled pixel is the truncated mean of one 2x2 block, with a registered valid/ready output stage.
module cam_pool2x2 #(
    parameter int COLS   = 64,
    parameter int ROWS   = 64,
    parameter int DATA_W = 16,
    localparam int CW  = $clog2(COLS),
    localparam int RW  = $clog2(ROWS),
    localparam int OCW = CW - 1,
    localparam int ORW = (RW > 1) ? RW - 1 : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_sof_i,
    input  logic [DATA_W-1:0] in_r_i,
    input  logic [DATA_W-1:0] in_g_i,
    input  logic [DATA_W-1:0] in_b_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_r_o,
    output logic [DATA_W-1:0] out_g_o,
    output logic [DATA_W-1:0] out_b_o,
    output logic [OCW-1:0]    out_col_o,
    output logic [ORW-1:0]    out_row_o,
    output logic              out_eof_o,
    output logic              sof_err_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_reg;
    logic [CW-1:0]     col_reg;
    logic [RW-1:0]     row_reg;
    logic              sof_err_reg;
    logic              out_valid_reg;
    logic              out_eof_reg;
    logic [OCW-1:0]    out_col_reg;
    logic [ORW-1:0]    out_row_reg;

    logic              accept;
    logic              do_pix;
    logic              out_load;
    logic [CW-1:0]     eff_col;
    logic [RW-1:0]     eff_row;
    logic [OCW-1:0]    pair_idx;
    logic [DATA_W-1:0] pix [3];

    assign in_ready_o = ~out_valid_reg | out_ready_i;
    assign accept     = in_valid_i & in_ready_o;
    // A sof pixel is always processed as (0,0), whatever the counters held.
    assign do_pix     = accept & (in_sof_i | (state_reg == RUN));
    assign eff_col    = in_sof_i ? '0 : col_reg;
    assign eff_row    = in_sof_i ? '0 : row_reg;
    assign pair_idx   = eff_col[CW-1:1];
    assign out_load   = do_pix & eff_col[0] & eff_row[0];

    assign pix[0] = in_r_i;
    assign pix[1] = in_g_i;
    assign pix[2] = in_b_i;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            col_reg     <= '0;
            row_reg     <= '0;
            sof_err_reg <= 1'b0;
        end else if (accept) begin
            if (in_sof_i) begin
                if (state_reg == RUN) sof_err_reg <= 1'b1;
                state_reg <= RUN;
                col_reg   <= CW'(1);
                row_reg   <= '0;
            end else if (state_reg == IDLE) begin
                sof_err_reg <= 1'b1;
            end else if (col_reg == CW'(COLS - 1)) begin
                col_reg <= '0;
                if (row_reg == RW'(ROWS - 1)) begin
                    row_reg   <= '0;
                    state_reg <= IDLE;
                end else begin
                    row_reg <= row_reg + 1'b1;
                end
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    // A new result can only load when in_ready_o is high, so a stalled result is never overwritten.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_reg <= 1'b0;
            out_eof_reg   <= 1'b0;
            out_col_reg   <= '0;
            out_row_reg   <= '0;
        end else if (out_load) begin
            out_valid_reg <= 1'b1;
            out_col_reg   <= pair_idx;
            out_row_reg   <= ORW'(eff_row >> 1);
            out_eof_reg   <= (eff_col == CW'(COLS - 1)) && (eff_row == RW'(ROWS - 1));
        end else if (out_ready_i) begin
            out_valid_reg <= 1'b0;
            out_eof_reg   <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : chan
        logic [DATA_W-1:0] hold_reg;
        logic [DATA_W:0]   lb_mem [COLS/2];
        logic [DATA_W:0]   lb_rd_reg;
        logic [DATA_W:0]   pair_sum;
        logic [DATA_W+1:0] quad_sum;
        logic [DATA_W-1:0] data_reg;

        assign pair_sum = {1'b0, hold_reg} + {1'b0, pix[gi]};
        assign quad_sum = {1'b0, pair_sum} + {1'b0, lb_rd_reg};

        // The line-buffer read is launched on the even-column pixel so it is ready for the odd one.
        always_ff @(posedge clk) begin
            if (do_pix && !eff_col[0]) begin
                hold_reg  <= pix[gi];
                lb_rd_reg <= lb_mem[pair_idx];
            end
            if (do_pix && eff_col[0] && !eff_row[0]) begin
                lb_mem[pair_idx] <= pair_sum;
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                data_reg <= '0;
            end else if (out_load) begin
                data_reg <= DATA_W'(quad_sum >> 2);
            end
        end
    end

    assign out_r_o     = chan[0].data_reg;
    assign out_g_o     = chan[1].data_reg;
    assign out_b_o     = chan[2].data_reg;
    assign out_valid_o = out_valid_reg;
    assign out_eof_o   = out_eof_reg;
    assign out_col_o   = out_col_reg;
    assign out_row_o   = out_row_reg;
    assign sof_err_o   = sof_err_reg;

endmodule

// File: tb/tb_cam_pool2x2.sv
// Directed bench for cam_pool2x2 on a 4x2 frame: one task per scenario, inline checks.
module tb_cam_pool2x2;

    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int DW   = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_r = '0, in_g = '0, in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_r, out_g, out_b;
    logic          out_col;
    logic          out_row;
    logic          out_eof;
    logic          sof_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] r;
        logic [DW-1:0] g;
        logic [DW-1:0] b;
        logic          col;
        logic          row;
        logic          eof;
    } out_t;

    out_t          q[$];
    logic [DW-1:0] fr_r [8];
    logic [DW-1:0] fr_g [8];
    logic [DW-1:0] fr_b [8];

    cam_pool2x2 #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_sof_i(in_sof),
        .in_r_i(in_r), .in_g_i(in_g), .in_b_i(in_b),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_r_o(out_r), .out_g_o(out_g), .out_b_o(out_b),
        .out_col_o(out_col), .out_row_o(out_row),
        .out_eof_o(out_eof), .sof_err_o(sof_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            q.push_back(out_t'({out_r, out_g, out_b, out_col, out_row, out_eof}));
            $display("out r=%0d g=%0d b=%0d col=%0d row=%0d eof=%0b", out_r, out_g, out_b, out_col, out_row, out_eof);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish required finish");
        $fatal(1, "watchdog");
    end

    // Drives one pixel from a negedge and returns at the negedge after it is accepted.
    task automatic send(input logic sof, input logic [DW-1:0] r, g, b, output int stalls);
        stalls   = 0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_r     = r;
        in_g     = g;
        in_b     = b;
        while (!in_ready && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input int first, input int last, input logic with_sof, output int stalls);
        int s;
        stalls = 0;
        for (int i = first; i <= last; i++) begin
            send(with_sof && (i == 0), fr_r[i], fr_g[i], fr_b[i], s);
            stalls += s;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        checks++;
        if ({out_r, out_g, out_b} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h required 0 0 0", out_r, out_g, out_b);
        end
        checks++;
        if ({out_col, out_row, out_eof, sof_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags col=%b row=%b eof=%b sof_err=%b required 0", out_col, out_row, out_eof, sof_err);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int st;
        out_t e0, e1;
        q.delete();
        fr_r = '{4, 8, 12, 16, 4, 8, 12, 16};
        fr_g = '{1, 2, 3, 4, 5, 6, 7, 8};
        fr_b = '{100, 100, 100, 100, 100, 100, 100, 100};
        send_frame(0, 7, 1'b1, st);
        checks++;
        if (out_valid !== 1'b1 || out_eof !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency out_valid=%b eof=%b required 1 1", out_valid, out_eof);
        end
        checks++;
        if (st != 0) begin
            errors++;
            $display("FAIL basic_rate stalls=%0d required 0", st);
        end
        repeat (2) @(negedge clk);
        e0 = '{r: 16'd6, g: 16'd3, b: 16'd100, col: 1'b0, row: 1'b0, eof: 1'b0};
        e1 = '{r: 16'd14, g: 16'd5, b: 16'd100, col: 1'b1, row: 1'b0, eof: 1'b1};
        checks++;
        if (q.size() != 2) begin
            errors++;
            $display("FAIL basic_count got %0d required 2", q.size());
        end else begin
            checks++;
            if (q[0] !== e0) begin errors++; $display("FAIL basic_out0 got %h required %h", q[0], e0); end
            checks++;
            if (q[1] !== e1) begin errors++; $display("FAIL basic_out1 got %h required %h", q[1], e1); end
        end
        $display("test_basic done");
    endtask

    task automatic test_saturate();
        int st;
        out_t e0, e1;
        q.delete();
        foreach (fr_r[i]) begin
            fr_r[i] = 16'hFFFF;
            fr_g[i] = 16'hFFFF;
            fr_b[i] = 16'hFFFF;
        end
        send_frame(0, 7, 1'b1, st);
        repeat (2) @(negedge clk);
        e0 = '{r: 16'hFFFF, g: 16'hFFFF, b: 16'hFFFF, col: 1'b0, row: 1'b0, eof: 1'b0};
        e1 = '{r: 16'hFFFF, g: 16'hFFFF, b: 16'hFFFF, col: 1'b1, row: 1'b0, eof: 1'b1};
        checks++;
        if (q.size() != 2) begin
            errors++;
            $display("FAIL sat_count got %0d required 2", q.size());
        end else begin
            checks++;
            if (q[0] !== e0) begin errors++; $display("FAIL sat_out0 got %h required %h", q[0], e0); end
            checks++;
            if (q[1] !== e1) begin errors++; $display("FAIL sat_out1 got %h required %h", q[1], e1); end
        end
        $display("test_saturate done");
    endtask

    task automatic test_trunc();
        int st;
        out_t e0, e1;
        q.delete();
        fr_r = '{1, 1, 3, 3, 1, 2, 3, 2};
        fr_g = '{1, 1, 1, 1, 1, 1, 1, 0};
        fr_b = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(0, 7, 1'b1, st);
        repeat (2) @(negedge clk);
        e0 = '{r: 16'd1, g: 16'd1, b: 16'd0, col: 1'b0, row: 1'b0, eof: 1'b0};
        e1 = '{r: 16'd2, g: 16'd0, b: 16'd0, col: 1'b1, row: 1'b0, eof: 1'b1};
        checks++;
        if (q.size() != 2) begin
            errors++;
            $display("FAIL trunc_count got %0d required 2", q.size());
        end else begin
            checks++;
            if (q[0] !== e0) begin errors++; $display("FAIL trunc_out0 got %h required %h", q[0], e0); end
            checks++;
            if (q[1] !== e1) begin errors++; $display("FAIL trunc_out1 got %h required %h", q[1], e1); end
        end
        $display("test_trunc done");
    endtask

    task automatic test_backpressure();
        int st;
        out_t e0, e1;
        q.delete();
        fr_r = '{10, 20, 30, 40, 50, 60, 70, 80};
        fr_g = '{0, 0, 0, 0, 0, 0, 0, 0};
        fr_b = '{9, 9, 9, 9, 9, 9, 9, 9};
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        send_frame(0, 5, 1'b1, st);
        in_valid = 1'b1;
        in_r = fr_r[6];
        in_g = fr_g[6];
        in_b = fr_b[6];
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_r !== 16'd35 || out_col !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d in_ready=%b out_valid=%b out_r=%0d col=%b required 0 1 35 0",
                         k, in_ready, out_valid, out_r, out_col);
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL bp_no_handshake got %0d outputs required 0", q.size());
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        send(1'b0, fr_r[7], fr_g[7], fr_b[7], st);
        in_valid = 1'b0;
        checks++;
        if (st != 0 || out_valid !== 1'b1 || out_eof !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume stalls=%0d out_valid=%b eof=%b required 0 1 1", st, out_valid, out_eof);
        end
        send_frame(0, 7, 1'b1, st);
        checks++;
        if (st != 0) begin
            errors++;
            $display("FAIL bp_rate stalls=%0d required 0", st);
        end
        repeat (2) @(negedge clk);
        e0 = '{r: 16'd35, g: 16'd0, b: 16'd9, col: 1'b0, row: 1'b0, eof: 1'b0};
        e1 = '{r: 16'd55, g: 16'd0, b: 16'd9, col: 1'b1, row: 1'b0, eof: 1'b1};
        checks++;
        if (q.size() != 4) begin
            errors++;
            $display("FAIL bp_count got %0d required 4", q.size());
        end else begin
            checks++;
            if (q[0] !== e0 || q[2] !== e0) begin
                errors++;
                $display("FAIL bp_out0 got %h %h required %h", q[0], q[2], e0);
            end
            checks++;
            if (q[1] !== e1 || q[3] !== e1) begin
                errors++;
                $display("FAIL bp_out1 got %h %h required %h", q[1], q[3], e1);
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_sof_err();
        int st;
        out_t e0, e1;
        // Mid-frame sof: a fresh restart must flag the error and pool the new frame from (0,0).
        do_reset();
        fr_r = '{999, 999, 999, 999, 0, 0, 0, 0};
        fr_g = '{0, 0, 0, 0, 0, 0, 0, 0};
        fr_b = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(0, 3, 1'b1, st);
        checks++;
        if (sof_err !== 1'b0) begin
            errors++;
            $display("FAIL sof_clean got %b required 0", sof_err);
        end
        fr_r = '{10, 20, 30, 40, 50, 60, 70, 80};
        send_frame(0, 7, 1'b1, st);
        repeat (2) @(negedge clk);
        checks++;
        if (sof_err !== 1'b1) begin
            errors++;
            $display("FAIL sof_midframe got %b required 1", sof_err);
        end
        e0 = '{r: 16'd35, g: 16'd0, b: 16'd0, col: 1'b0, row: 1'b0, eof: 1'b0};
        e1 = '{r: 16'd55, g: 16'd0, b: 16'd0, col: 1'b1, row: 1'b0, eof: 1'b1};
        checks++;
        if (q.size() != 2) begin
            errors++;
            $display("FAIL sof_count got %0d required 2", q.size());
        end else begin
            checks++;
            if (q[0] !== e0 || q[1] !== e1) begin
                errors++;
                $display("FAIL sof_outputs got %h %h required %h %h", q[0], q[1], e0, e1);
            end
        end
        // Pixels without sof while idle are discarded and latch the error.
        do_reset();
        send(1'b0, 16'd7, 16'd7, 16'd7, st);
        send(1'b0, 16'd7, 16'd7, 16'd7, st);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sof_err !== 1'b1 || q.size() != 0) begin
            errors++;
            $display("FAIL sof_idle sof_err=%b outputs=%0d required 1 0", sof_err, q.size());
        end
        send_frame(0, 7, 1'b1, st);
        repeat (2) @(negedge clk);
        checks++;
        if (sof_err !== 1'b1 || q.size() != 2) begin
            errors++;
            $display("FAIL sof_sticky sof_err=%b outputs=%0d required 1 2", sof_err, q.size());
        end else begin
            checks++;
            if (q[0] !== e0 || q[1] !== e1) begin
                errors++;
                $display("FAIL sof_idle_outputs got %h %h required %h %h", q[0], q[1], e0, e1);
            end
        end
        $display("test_sof_err done");
    endtask

    task automatic test_reset_midframe();
        int st;
        out_t e0, e1;
        fr_r = '{10, 20, 30, 40, 50, 60, 70, 80};
        fr_g = '{0, 0, 0, 0, 0, 0, 0, 0};
        fr_b = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(0, 4, 1'b1, st);
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_eof !== 1'b0 || sof_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_flags valid=%b eof=%b sof_err=%b in_ready=%b required 0 0 0 1",
                     out_valid, out_eof, sof_err, in_ready);
        end
        checks++;
        if ({out_r, out_g, out_b, out_col, out_row} !== '0) begin
            errors++;
            $display("FAIL rst_mid_data got %0d %0d %0d col=%b row=%b required all 0",
                     out_r, out_g, out_b, out_col, out_row);
        end
        fr_r = '{4, 8, 12, 16, 4, 8, 12, 16};
        send_frame(0, 4, 1'b1, st);
        checks++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_early out_valid=%b outputs=%0d required 0 0", out_valid, q.size());
        end
        send_frame(5, 5, 1'b0, st);
        checks++;
        if (out_valid !== 1'b1 || out_r !== 16'd6) begin
            errors++;
            $display("FAIL rst_mid_first out_valid=%b out_r=%0d required 1 6", out_valid, out_r);
        end
        send_frame(6, 7, 1'b0, st);
        repeat (2) @(negedge clk);
        e0 = '{r: 16'd6, g: 16'd0, b: 16'd0, col: 1'b0, row: 1'b0, eof: 1'b0};
        e1 = '{r: 16'd14, g: 16'd0, b: 16'd0, col: 1'b1, row: 1'b0, eof: 1'b1};
        checks++;
        if (q.size() != 2) begin
            errors++;
            $display("FAIL rst_mid_count got %0d required 2", q.size());
        end else begin
            checks++;
            if (q[0] !== e0 || q[1] !== e1) begin
                errors++;
                $display("FAIL rst_mid_outputs got %h %h required %h %h", q[0], q[1], e0, e1);
            end
        end
        $display("test_reset_midframe done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_trunc();
        test_backpressure();
        test_sof_err();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
